// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture / filter pipeline:
// RGB444 field layout, capture FSM encoding and default frame geometry.
package cam_capture_pkg;

  localparam int CH_W  = 4;
  localparam int PIX_W = 3 * CH_W;
  localparam int R_MSB = 11;
  localparam int G_MSB = 7;
  localparam int B_MSB = 3;

  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;
  localparam int ADDR_W_DEF   = 17;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2
  } state_t;

endpackage

// File: rtl/cam_capture_rgb565_to_444.sv
// Combinational RGB565 -> RGB444 packing; each channel keeps its top four bits.
module rgb565_to_444
  import cam_capture_pkg::*;
(
  input  logic [15:0]      rgb565_i,
  output logic [PIX_W-1:0] rgb444_o
);

  // Low-order channel bits are dropped by truncation.
  logic unused_bits;
  assign unused_bits = ^{rgb565_i[11], rgb565_i[6:5], rgb565_i[0]};

  assign rgb444_o[R_MSB -: CH_W] = rgb565_i[15:12];
  assign rgb444_o[G_MSB -: CH_W] = rgb565_i[10:7];
  assign rgb444_o[B_MSB -: CH_W] = rgb565_i[4:1];

endmodule

// File: rtl/cam_capture.sv
// Camera byte-stream capture: assembles RGB444 pixels from whole frames only,
// clipped to H_ACTIVE x V_ACTIVE, with a linear frame-buffer write address.
//
// state         | meaning
// ST_IDLE       | after reset; waiting to see vsync high so no partial frame is taken
// ST_WAIT_FRAME | in vertical blanking; vsync falling edge with capture_en starts a frame
// ST_CAPTURE    | taking bytes; vsync rising edge closes the frame
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cam_en_i,
  input  logic              cam_vsync_i,
  input  logic              cam_href_i,
  input  logic [7:0]        cam_data_i,
  input  logic              capture_en_i,
  output logic [PIX_W-1:0]  pixel_out_o,
  output logic              pixel_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              frame_done_o,
  output logic [8:0]        line_cnt_o,
  output logic              busy_o
);

  localparam int                X_W       = $clog2(H_ACTIVE + 1);
  localparam logic [X_W-1:0]    X_LIM     = X_W'(H_ACTIVE);
  localparam logic [8:0]        Y_LIM     = 9'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              vs_q, vs_d, hr_q, hr_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              pv_q, pv_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic              fd_q, fd_d;

  logic [PIX_W-1:0]  pix_conv;
  logic              vs_rise, vs_fall, hr_fall;

  rgb565_to_444 u_rgb565_to_444 (
    .rgb565_i ({hi_q, cam_data_i}),
    .rgb444_o (pix_conv)
  );

  assign vs_rise = cam_en_i &  cam_vsync_i & ~vs_q;
  assign vs_fall = cam_en_i & ~cam_vsync_i &  vs_q;
  assign hr_fall = cam_en_i & ~cam_href_i  &  hr_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    base_d  = base_q;
    vs_d    = vs_q;
    hr_d    = hr_q;
    pix_d   = pix_q;
    pv_d    = 1'b0;
    wa_d    = wa_q;
    fd_d    = 1'b0;

    if (cam_en_i) begin
      vs_d = cam_vsync_i;
      hr_d = cam_href_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (cam_en_i && cam_vsync_i) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (vs_fall && capture_en_i) begin
          state_d = ST_CAPTURE;
          phase_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          base_d  = '0;
        end
      end
      ST_CAPTURE: begin
        // A vsync edge takes priority over any byte on the same strobe.
        if (vs_rise) begin
          state_d = ST_WAIT_FRAME;
          fd_d    = (y_q == Y_LIM);
        end else if (cam_en_i && cam_href_i) begin
          if (!phase_q) begin
            hi_d    = cam_data_i;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q < X_LIM && y_q < Y_LIM) begin
              pv_d   = 1'b1;
              pix_d  = pix_conv;
              wa_d   = addr_q;
              addr_d = addr_q + ADDR_W'(1);
            end
            if (x_q < X_LIM) x_d = x_q + X_W'(1);
          end
        end else if (hr_fall) begin
          // Line base advances by H_ACTIVE so short lines leave holes.
          x_d     = '0;
          phase_d = 1'b0;
          if (y_q < Y_LIM) y_d = y_q + 9'd1;
          if (y_q + 9'd1 < Y_LIM) begin
            base_d = base_q + LINE_STEP;
            addr_d = base_q + LINE_STEP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      hi_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      base_q  <= '0;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      pix_q   <= '0;
      pv_q    <= 1'b0;
      wa_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      vs_q    <= vs_d;
      hr_q    <= hr_d;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      wa_q    <= wa_d;
      fd_q    <= fd_d;
    end
  end

  assign pixel_out_o   = pix_q;
  assign pixel_valid_o = pv_q;
  assign wr_addr_o     = wa_q;
  assign frame_done_o  = fd_q;
  assign line_cnt_o    = y_q;
  assign busy_o        = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture on a 4x2 window: frames are described as lines of
// byte counts and the expected pixels/addresses are derived per byte.
module tb_cam_capture;

  localparam int TH = 4;
  localparam int TV = 2;
  localparam int TA = 4;

  logic          clk = 1'b0;
  logic          rst, cam_en, cam_vsync, cam_href, capture_en;
  logic [7:0]    cam_data;
  logic [11:0]   pixel_out;
  logic          pixel_valid;
  logic [TA-1:0] wr_addr;
  logic          frame_done;
  logic [8:0]    line_cnt;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int lb[8];
  int cen_off_line = -1;

  always #5 clk = ~clk;

  cam_capture #(.H_ACTIVE(TH), .V_ACTIVE(TV), .ADDR_W(TA)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cam_en_i      (cam_en),
    .cam_vsync_i   (cam_vsync),
    .cam_href_i    (cam_href),
    .cam_data_i    (cam_data),
    .capture_en_i  (capture_en),
    .pixel_out_o   (pixel_out),
    .pixel_valid_o (pixel_valid),
    .wr_addr_o     (wr_addr),
    .frame_done_o  (frame_done),
    .line_cnt_o    (line_cnt),
    .busy_o        (busy)
  );

  function automatic logic [11:0] exp_pix(input int v);
    return 12'(((v >> 12) & 15) * 256 + ((v >> 7) & 15) * 16 + ((v >> 1) & 15));
  endfunction

  function automatic logic [7:0] pick(input int mode, input int j);
    case (mode)
      1: return (j % 2 == 0) ? 8'hF8 : 8'h00;
      2: if ((j / 2) % 2 == 0) return (j % 2 == 0) ? 8'h07 : 8'hE0;
         else                  return (j % 2 == 0) ? 8'h00 : 8'h1F;
      default: return 8'($urandom);
    endcase
  endfunction

  // Idle cycles with junk on gated inputs, then one cam_en strobe; returns at
  // the negedge after the sampling edge.
  task automatic strobe(input logic v, input logic h, input logic [7:0] d);
    int g;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) begin
      cam_en    = 1'b0;
      cam_vsync = 1'($urandom_range(0, 1));
      cam_href  = 1'($urandom_range(0, 1));
      cam_data  = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (pixel_valid !== 1'b0 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_quiet pv=%b fd=%b required 0 0", pixel_valid, frame_done);
      end
    end
    cam_en = 1'b1; cam_vsync = v; cam_href = h; cam_data = d;
    @(negedge clk);
    cam_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cam_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({pixel_out, pixel_valid, wr_addr, frame_done, line_cnt, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs pix=%h pv=%b addr=%0d fd=%b line=%0d busy=%b required all 0",
               pixel_out, pixel_valid, wr_addr, frame_done, line_cnt, busy);
    end
    rst = 1'b0;
  endtask

  // Drives one frame (vsync low, nl lines of lb[] bytes, vsync high).
  task automatic run_frame(input int nl, input bit cap, input int mode, input int rst_at,
                           input bit end_hr);
    bit         c, ev;
    int         falls;
    logic [7:0] b, hi;
    c  = cap;
    hi = 8'h00;
    strobe(1'b0, 1'b0, 8'($urandom));
    n_checks++;
    if (busy !== c || (c && line_cnt !== 9'd0)) begin
      n_fail++;
      $display("FAIL frame_start busy=%b line=%0d required busy=%b line=0", busy, line_cnt, c);
    end
    for (int l = 0; l < nl; l++) begin
      if (l == cen_off_line) capture_en = 1'b0;
      strobe(1'b0, 1'b0, 8'($urandom));
      for (int j = 0; j < lb[l]; j++) begin
        b = pick(mode, j);
        if (j % 2 == 0) hi = b;
        strobe(1'b0, 1'b1, b);
        ev = c && (j % 2 == 1) && (l < TV) && (j / 2 < TH);
        n_checks++;
        if (pixel_valid !== ev) begin
          n_fail++;
          $display("FAIL pixel_valid line=%0d byte=%0d got=%b required=%b", l, j, pixel_valid, ev);
        end else if (ev && (pixel_out !== exp_pix(int'({hi, b})) ||
                            wr_addr !== TA'(l * TH + j / 2))) begin
          n_fail++;
          $display("FAIL pixel_data line=%0d byte=%0d got pix=%h addr=%0d required pix=%h addr=%0d",
                   l, j, pixel_out, wr_addr, exp_pix(int'({hi, b})), l * TH + j / 2);
        end
        if (c && l == 0 && j == rst_at) begin
          do_reset();
          c = 1'b0;
        end
      end
      if (!(end_hr && l == nl - 1)) begin
        strobe(1'b0, 1'b0, 8'($urandom));
        if (c) begin
          n_checks++;
          if (line_cnt !== 9'((l + 1 < TV) ? l + 1 : TV)) begin
            n_fail++;
            $display("FAIL line_cnt got=%0d required=%0d", line_cnt, (l + 1 < TV) ? l + 1 : TV);
          end
        end
      end
    end
    falls = end_hr ? nl - 1 : nl;
    strobe(1'b1, end_hr, 8'($urandom));
    n_checks++;
    if (frame_done !== (c && falls >= TV) || pixel_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end fd=%b pv=%b busy=%b required fd=%b pv=0 busy=0",
               frame_done, pixel_valid, busy, c && falls >= TV);
    end
    strobe(1'b1, 1'b0, 8'($urandom));
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_width got=%b required=0", frame_done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    lb[0] = 8; lb[1] = 8;
    run_frame(2, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_basic();
    lb[0] = 8; lb[1] = 8;
    run_frame(2, 1'b1, 1, -1, 1'b0);
  endtask

  task automatic test_colors();
    lb[0] = 8; lb[1] = 8;
    run_frame(2, 1'b1, 2, -1, 1'b0);
  endtask

  task automatic test_clip();
    lb[0] = 12; lb[1] = 8; lb[2] = 8;
    run_frame(2, 1'b1, 0, -1, 1'b0);
    run_frame(3, 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_odd_line();
    lb[0] = 5; lb[1] = 8;
    run_frame(2, 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    lb[0] = 8; lb[1] = 8;
    run_frame(2, 1'b1, 1, 5, 1'b0);
    run_frame(2, 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_capture_en();
    lb[0] = 8; lb[1] = 8;
    cen_off_line = 1;
    run_frame(2, 1'b1, 0, -1, 1'b0);
    cen_off_line = -1;
    run_frame(2, 1'b0, 0, -1, 1'b0);
    capture_en = 1'b1;
    run_frame(2, 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_vsync_href();
    lb[0] = 3;
    run_frame(1, 1'b1, 0, -1, 1'b1);
    lb[0] = 8; lb[1] = 6;
    run_frame(2, 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_random();
    int nl;
    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(1, 3);
      for (int i = 0; i < nl; i++) lb[i] = $urandom_range(1, 12);
      run_frame(nl, 1'b1, 0, -1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; cam_en = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    cam_data = 8'h00; capture_en = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_colors();
    test_clip();
    test_odd_line();
    test_reset_mid();
    test_capture_en();
    test_vsync_href();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
